sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Two-requester round-robin arbiter in front of the single-port `sram` macro (synchronous write, registered read). It shares one SRAM between two independent masters: one access per cycle, with fair alternation under contention. It routes the one-cycle-latency read data back to the master that issued the read. Per-master saturating access counters are provided for debug and performance.

## Interface
- `ADDR_W`, default 4: SRAM address width.
- `DATA_W`, default 8: SRAM data width.
- `CNT_W`, default 16: width of each access counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req0`, `req1`  in  1  master n requests an access this cycle.
- `we0`, `we1`  in  1  1 = write, 0 = read; qualified by `reqn`.
- `addr0`, `addr1`  in  ADDR_W  access address for master n.
- `wdata0`, `wdata1`  in  DATA_W  write data for master n.
- `gnt0`, `gnt1`  out  1  combinational grant; the access is accepted at the edge where `reqn & gntn`.
- `rvalid0`, `rvalid1`  out  1  read data for master n is on `rdata` this cycle.
- `rdata`  out  DATA_W  read data, shared by both masters; driven from `sram_dout`.
- `cnt0`, `cnt1`  out  CNT_W  accepted accesses per master, saturating.
- `sram_we`  out  1  to `sram.we`.
- `sram_addr`  out  ADDR_W  to `sram.addr`.
- `sram_din`  out  DATA_W  to `sram.din`.
- `sram_dout`  in  DATA_W  from `sram.dout`; registered inside the SRAM, valid the cycle after the address edge.

## Operation
- **Priority pointer `prio`** (1 bit) selects which master wins on contention. `prio` = 0 means master 0 is preferred.
- **Grant logic** (combinational):
  - Only `req0`: `gnt0` = 1.
  - Only `req1`: `gnt1` = 1.
  - Both: grant goes to master `prio`.
  - Neither: both grants are 0.
  - `gnt0` and `gnt1` are never high together.
- **Pointer update:** on each edge with an accepted access, `prio` becomes the index of the non-granted master. With no access, `prio` holds.
- **SRAM mux:**
  - `sram_addr`/`sram_din` follow the granted master.
  - `sram_we` = granted master's `we`.
  - When nothing is granted: `sram_we` = 0, and `sram_addr`/`sram_din` hold master 0's inputs (don't-care for the SRAM, but defined).
- **Read tracking:** a register `rd_pend` (valid bit plus owner bit) is loaded at each edge.
  - Valid = 1 if the accepted access is a read; owner = granted master.
  - Otherwise valid = 0.
  - `rvalidn` = `rd_pend.valid & (owner == n)`.
- **Writes** produce no response.
- **Counters:** `cntn` increments by 1 on each accepted access by master n (read or write). It holds at all-ones once it reaches all-ones.
- **Reset:**
  - While `rst` = 1, `gnt0`, `gnt1` and `sram_we` are forced to 0.
  - Asynchronously cleared: `prio` = 0, `rd_pend` = 0, `cnt0` = `cnt1` = 0.
  - So `rvalid0` = `rvalid1` = 0.
  - A read accepted on the edge before reset asserts is dropped: no `rvalid` follows.

## Timing
- **Reset values:** `gnt0`/`gnt1` = 0, `rvalid0`/`rvalid1` = 0, `cnt0`/`cnt1` = 0, `sram_we` = 0, `sram_addr` = `addr0`, `sram_din` = `wdata0`, `rdata` = `sram_dout`.
- **Throughput:** 1 access per cycle. Back-to-back accepts are allowed, from the same master or alternating.
- **Read latency:** the read is accepted at edge E. `rvalidn` and `rdata` are valid in the cycle between E and E+1, and `rvalidn` is high for exactly that one cycle.
- **Write then read, same address, adjacent cycles:** the read returns the new data. The write commits at edge E and the read samples at edge E+1.
- **Handshake:**
  - A master holds `req`/`we`/`addr`/`wdata` stable until it sees `gnt` high at an edge.
  - Dropping `req` before grant is allowed; no access occurs.
- **Fairness:** under continuous contention, grants alternate every cycle. A requesting master waits at most 1 cycle.

## Test plan
- **Reset:** assert `rst` mid-cycle with `req0` = 1.
  - Required: `gnt0` = 0, `sram_we` = 0, counters 0, no `rvalid`.
  - After release, the first contended grant goes to master 0.
- **Single master:** master 0 writes 0xAA to addr 0x1, then 0x55 to addr 0x2, then reads 0x1 and 0x2 back to back.
  - Required: `rvalid0` in the cycles after each read accept, with `rdata` = 0xAA then 0x55.
  - Required: `cnt0` = 4, `rvalid1` never asserted.
- **Contention:** `req0` = `req1` = 1 for 6 cycles, both reading different addresses.
  - Required: grants go 0, 1, 0, 1, 0, 1.
  - Required: each `rvalid` is routed to the correct master one cycle later with that address's data.
  - Required: `cnt0` = `cnt1` = 3.
- **Cross-master write then read:** master 1 writes 0x3C to 0xF at edge E, master 0 reads 0xF at edge E+1.
  - Required: `rvalid0` with `rdata` = 0x3C.
- **Counter saturation:** with `CNT_W` = 2, give 5 accepted accesses from master 1.
  - Required: `cnt1` = 3 and holds.
- **Reset with read in flight:** assert `rst` right after a read accept edge.
  - Required: `rvalid` stays 0, and the next read after reset returns normally.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port SRAM with registered
// read data. One access per cycle; read data is steered back to its issuer one
// cycle after acceptance; per-master saturating access counters for debug.
module sram_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_din,
  input  logic [DATA_W-1:0] sram_dout
);

  // Outstanding read: the SRAM returns data one cycle after the address edge,
  // so only one read can ever be in flight.
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_pend_t;

  logic             prio_q, prio_d;
  rd_pend_t         rd_pend_q, rd_pend_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             accept;

  // Grant: single requester wins outright, contention resolved by prio_q.
  // Both grants are held low while reset is asserted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; an unassigned path would infer a latch.
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      if (req0 && (!req1 || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // SRAM port mux: follow the granted master, default to master 0 when idle.
  always_comb begin
    sram_addr = gnt1 ? addr1  : addr0;
    sram_din  = gnt1 ? wdata1 : wdata0;
    sram_we   = (gnt0 & we0) | (gnt1 & we1);
  end

  // Next state: pointer moves to the loser, read tracking, saturating counters.
  always_comb begin
    accept          = gnt0 | gnt1;
    prio_d          = prio_q;
    rd_pend_d       = '0;
    cnt0_d          = cnt0_q;
    cnt1_d          = cnt1_q;
    if (accept) begin
      prio_d          = gnt0;
      rd_pend_d.valid = ~sram_we;
      rd_pend_d.owner = gnt1;
    end
    if (gnt0 && (cnt0_q != '1)) cnt0_d = cnt0_q + CNT_W'(1);
    if (gnt1 && (cnt1_q != '1)) cnt1_d = cnt1_q + CNT_W'(1);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q    <= 1'b0;
      rd_pend_q <= '0;
      cnt0_q    <= '0;
      cnt1_q    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      prio_q    <= prio_d;
      rd_pend_q <= rd_pend_d;
      cnt0_q    <= cnt0_d;
      cnt1_q    <= cnt1_d;
    end
  end

  assign rvalid0 = rd_pend_q.valid & ~rd_pend_q.owner;
  assign rvalid1 = rd_pend_q.valid &  rd_pend_q.owner;
  assign rdata   = sram_dout;
  assign cnt0    = cnt0_q;
  assign cnt1    = cnt1_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: an SRAM model, a transaction-level
// reference model compared every cycle, directed scenarios with literal
// expectations, then constrained-random traffic that obeys the handshake.
module tb_sram_arbiter;

  localparam logic [7:0] INIT [16] = '{8'h0B, 8'h30, 8'h55, 8'h7A, 8'h9F, 8'hC4,
                                       8'hE9, 8'h0E, 8'h33, 8'h58, 8'h7D, 8'hA2,
                                       8'hC7, 8'hEC, 8'h11, 8'h36};

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, sram_we;
  logic [7:0] rdata, sram_din, sram_dout;
  logic [3:0] sram_addr;
  logic [15:0] cnt0, cnt1;
  // Narrow-counter instance sharing the same stimulus.
  logic       s_gnt0, s_gnt1, s_rvalid0, s_rvalid1, s_sram_we;
  logic [7:0] s_rdata, s_sram_din;
  logic [3:0] s_sram_addr;
  logic [1:0] s_cnt0, s_cnt1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sram_arbiter #(.ADDR_W(4), .DATA_W(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .cnt0(cnt0), .cnt1(cnt1), .sram_we(sram_we),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
  );

  sram_arbiter #(.ADDR_W(4), .DATA_W(8), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(s_gnt0), .gnt1(s_gnt1), .rvalid0(s_rvalid0), .rvalid1(s_rvalid1),
    .rdata(s_rdata), .cnt0(s_cnt0), .cnt1(s_cnt1), .sram_we(s_sram_we),
    .sram_addr(s_sram_addr), .sram_din(s_sram_din), .sram_dout(sram_dout)
  );

  // SRAM macro model: synchronous write, registered read, contents not reset.
  logic [7:0] mem [16] = INIT;
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_din;
    sram_dout <= mem[sram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [7:0] exp_mem [16] = INIT;
  int         m_last;       // master served most recently (1 => master 0 preferred)
  bit         m_pv;         // a read response is due this cycle
  int         m_po;         // its owner
  logic [7:0] m_pd;         // its data
  int         m_cnt0, m_cnt1;

  function automatic int pick(input bit r0, input bit r1, input int last);
    if (r0 && r1) return 1 - last;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  function automatic int sat(input int c, input int w);
    int top;
    top = (1 << w) - 1;
    return (c > top) ? top : c;
  endfunction

  always @(posedge clk or posedge rst) begin
    int w;
    if (rst) begin
      m_last <= 1;
      m_pv   <= 1'b0;
      m_po   <= 0;
      m_pd   <= '0;
      m_cnt0 <= 0;
      m_cnt1 <= 0;
    end else begin
      w = pick(req0, req1, m_last);
      m_pv <= 1'b0;
      if (w >= 0) begin
        m_last <= w;
        if (w == 0) m_cnt0 <= m_cnt0 + 1;
        else        m_cnt1 <= m_cnt1 + 1;
        if ((w == 0 ? we0 : we1) == 1'b1) begin
          exp_mem[w == 0 ? addr0 : addr1] <= (w == 0 ? wdata0 : wdata1);
        end else begin
          m_pv <= 1'b1;
          m_po <= w;
          m_pd <= exp_mem[w == 0 ? addr0 : addr1];
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    int w;
    if (rst) begin
      check("rst_gnt0", 32'(gnt0), 0);
      check("rst_gnt1", 32'(gnt1), 0);
      check("rst_sram_we", 32'(sram_we), 0);
      check("rst_sram_addr", 32'(sram_addr), 32'(addr0));
      check("rst_rvalid0", 32'(rvalid0), 0);
      check("rst_rvalid1", 32'(rvalid1), 0);
      check("rst_cnt0", 32'(cnt0), 0);
      check("rst_cnt1", 32'(cnt1), 0);
    end else begin
      w = pick(req0, req1, m_last);
      check("gnt0", 32'(gnt0), 32'(w == 0));
      check("gnt1", 32'(gnt1), 32'(w == 1));
      check("sram_we", 32'(sram_we), (w == 0) ? 32'(we0) : (w == 1) ? 32'(we1) : 0);
      check("sram_addr", 32'(sram_addr), (w == 1) ? 32'(addr1) : 32'(addr0));
      check("sram_din", 32'(sram_din), (w == 1) ? 32'(wdata1) : 32'(wdata0));
      check("rvalid0", 32'(rvalid0), 32'(m_pv && m_po == 0));
      check("rvalid1", 32'(rvalid1), 32'(m_pv && m_po == 1));
      if (m_pv) check("rdata", 32'(rdata), 32'(m_pd));
      check("cnt0", 32'(cnt0), sat(m_cnt0, 16));
      check("cnt1", 32'(cnt1), sat(m_cnt1, 16));
      check("sat_cnt0", 32'(s_cnt0), sat(m_cnt0, 2));
      check("sat_cnt1", 32'(s_cnt1), sat(m_cnt1, 2));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic setm(input int m, input bit r, input bit w, input logic [3:0] a,
                      input logic [7:0] d);
    if (m == 0) begin
      req0 = r; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = w; addr1 = a; wdata1 = d;
    end
  endtask

  task automatic idle();
    setm(0, 1'b0, 1'b0, 4'h0, 8'h00);
    setm(1, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic new_txn(input int m);
    setm(m, $urandom_range(3) != 0, 1'($urandom_range(1)), 4'($urandom_range(15)),
         8'($urandom_range(255)));
  endtask

  initial begin
    logic [3:0] a0, a1, ga;
    bit g0, g1;

    // Reset held from time 0, with master 0 already requesting a write.
    rst = 1'b1;
    idle();
    setm(0, 1'b1, 1'b1, 4'h3, 8'h77);
    cyc();
    cyc();
    #1;
    check("init_gnt0", 32'(gnt0), 0);
    check("init_sram_we", 32'(sram_we), 0);
    check("init_sram_addr", 32'(sram_addr), 32'h3);
    check("init_cnt0", 32'(cnt0), 0);
    check("init_rvalid0", 32'(rvalid0), 0);
    idle();
    rst = 1'b0;
    cyc();

    // Reset asserted mid-cycle while master 0 requests.
    setm(0, 1'b1, 1'b1, 4'h3, 8'h77);
    #1 check("pre_rst_gnt0", 32'(gnt0), 1);
    #1 rst = 1'b1;
    #1 check("mid_rst_gnt0", 32'(gnt0), 0);
    check("mid_rst_sram_we", 32'(sram_we), 0);
    cyc();
    cyc();
    check("mid_rst_cnt0", 32'(cnt0), 0);
    check("mid_rst_rvalid0", 32'(rvalid0), 0);
    idle();
    rst = 1'b0;

    // Contention: six reads each side pending, grants must alternate from 0.
    a0 = 4'd4;
    a1 = 4'd8;
    setm(0, 1'b1, 1'b0, a0, 8'h00);
    setm(1, 1'b1, 1'b0, a1, 8'h00);
    for (int k = 0; k < 6; k++) begin
      #1;
      check("cont_gnt0", 32'(gnt0), 32'(k % 2 == 0));
      check("cont_gnt1", 32'(gnt1), 32'(k % 2 == 1));
      ga = (k % 2 == 0) ? a0 : a1;
      cyc();
      check("cont_rvalid0", 32'(rvalid0), 32'(k % 2 == 0));
      check("cont_rvalid1", 32'(rvalid1), 32'(k % 2 == 1));
      check("cont_rdata", 32'(rdata), 32'(INIT[ga]));
      if (k % 2 == 0) begin
        a0 = a0 + 4'd1;
        setm(0, 1'b1, 1'b0, a0, 8'h00);
      end else begin
        a1 = a1 + 4'd1;
        setm(1, 1'b1, 1'b0, a1, 8'h00);
      end
    end
    idle();
    check("cont_cnt0", 32'(cnt0), 3);
    check("cont_cnt1", 32'(cnt1), 3);

    // Reset right after a read is accepted: its response is dropped.
    setm(0, 1'b1, 1'b0, 4'h7, 8'h00);
    cyc();
    rst = 1'b1;
    #1 check("flight_rvalid0", 32'(rvalid0), 0);
    idle();
    cyc();
    rst = 1'b0;
    setm(0, 1'b1, 1'b0, 4'h7, 8'h00);
    cyc();
    check("after_rst_rvalid0", 32'(rvalid0), 1);
    check("after_rst_rdata", 32'(rdata), 32'h0E);
    idle();

    // Single master: two writes then two back-to-back reads.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    setm(0, 1'b1, 1'b1, 4'h1, 8'hAA);
    cyc();
    setm(0, 1'b1, 1'b1, 4'h2, 8'h55);
    cyc();
    setm(0, 1'b1, 1'b0, 4'h1, 8'h00);
    cyc();
    setm(0, 1'b1, 1'b0, 4'h2, 8'h00);
    check("single_rvalid0_a", 32'(rvalid0), 1);
    check("single_rdata_a", 32'(rdata), 32'hAA);
    cyc();
    idle();
    check("single_rvalid0_b", 32'(rvalid0), 1);
    check("single_rdata_b", 32'(rdata), 32'h55);
    check("single_rvalid1", 32'(rvalid1), 0);
    check("single_cnt0", 32'(cnt0), 4);

    // Cross-master write then read in adjacent cycles.
    setm(1, 1'b1, 1'b1, 4'hF, 8'h3C);
    cyc();
    setm(1, 1'b0, 1'b0, 4'h0, 8'h00);
    setm(0, 1'b1, 1'b0, 4'hF, 8'h00);
    cyc();
    idle();
    check("cross_rvalid0", 32'(rvalid0), 1);
    check("cross_rvalid1", 32'(rvalid1), 0);
    check("cross_rdata", 32'(rdata), 32'h3C);

    // Saturation of the 2-bit counter instance.
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      setm(1, 1'b1, 1'b1, 4'(10 + i), 8'(i * 3));
      cyc();
      check("sat_cnt1_step", 32'(s_cnt1), (i >= 2) ? 3 : i + 1);
    end
    idle();
    cyc();
    check("sat_cnt1_hold", 32'(s_cnt1), 3);
    check("wide_cnt1", 32'(cnt1), 5);

    // Random traffic: each master holds its request until granted, may drop it.
    for (int n = 0; n < 3000; n++) begin
      #2;
      g0 = gnt0;
      g1 = gnt1;
      cyc();
      if (!req0 || g0) new_txn(0);
      else if ($urandom_range(7) == 0) req0 = 1'b0;
      if (!req1 || g1) new_txn(1);
      else if ($urandom_range(7) == 0) req1 = 1'b0;
    end
    idle();
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
